key_event_gen: RTL and testbench
================================

Name: key_event_gen

Overview:
- Front end for board push-buttons. Converts raw active-low `key_sw` levels into clean, debounced per-key events for counters, menus and mode toggles.
- Replaces ad-hoc edge detectors: consumers get single-cycle `key_press` / `key_release` pulses and a stable `key_down` level.
- Per-key two-flop synchronizer, debounce FSM and optional auto-repeat.

Parameters:
- N_KEYS, 4, number of independent keys.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change; legal range ≥2.
- REPEAT_DELAY_CYCLES, 25000000, cycles a key must stay accepted-pressed before the first repeat pulse; ≥1.
- REPEAT_PERIOD_CYCLES, 5000000, cycles between subsequent repeat pulses; ≥1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous reset, active low.
- key_sw  input  N_KEYS  raw buttons, active low (0 = pressed), asynchronous to clk.
- key_down  output  N_KEYS  debounced level, 1 = key accepted as pressed.
- key_press  output  N_KEYS  one-cycle pulse per accepted press (and per repeat when enabled).
- key_release  output  N_KEYS  one-cycle pulse per accepted release.
- key_repeat  output  N_KEYS  high together with key_press when that pulse is a repeat.
- any_down  output  1  OR of key_down.

Behaviour:
- All keys are fully independent; the description below is per key i.
- Reset (reset_n low at a clk edge):
  - Synchronizer flops load "released".
  - FSM goes to RELEASED; counters clear.
  - key_down, key_press, key_release, key_repeat and any_down are 0 from the next cycle.
  - Reset mid-debounce or mid-hold discards the event with no release pulse.
  - A key held through reset is re-debounced as a fresh press afterwards.
- Synchronizer:
  - s = ~key_sw[i] through two flops.
  - The FSM samples s, so 2 cycles of input latency.
- Debounce counter: one counter per key, wide enough for the largest of the three parameters (clog2).
- FSM states and transitions:
  - RELEASED: s=1 → DEB_PRESS, cnt=1.
  - DEB_PRESS:
    - s=0 → RELEASED, no event.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED; key_press=1 for one cycle; key_down=1.
    - Else cnt+1.
  - PRESSED: s=0 → DEB_RELEASE, cnt=1. The repeat timer freezes.
  - DEB_RELEASE:
    - s=1 → PRESSED; repeat timer resumes from its frozen value; no event.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 → RELEASED; key_release=1 for one cycle; key_down=0.
    - Else cnt+1.
- key_down is 1 throughout PRESSED and DEB_RELEASE.
- Timing: with key_sw[i] first sampled low at edge 0 and held, the state is PRESSED after edge DEBOUNCE_CYCLES+1, and key_press is high for the following cycle only. Release latency is identical.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES samples produces no event and does not change key_down.
- Pulse rules:
  - key_press and key_release are never high in the same cycle for one key.
  - Different keys may pulse in the same cycle.
- All outputs are registered; no combinational path from key_sw.

Optional Feature:
- Macro: KEY_EVENT_GEN_AUTO_REPEAT_EN.
- Defined:
  - The repeat timer starts at 0 in the cycle PRESSED is entered and counts cycles spent in PRESSED.
  - At count REPEAT_DELAY_CYCLES: key_press=1 and key_repeat=1 for one cycle; timer reloads.
  - Then a further pulse pair every REPEAT_PERIOD_CYCLES while held.
  - Timer clears on entry to RELEASED.
  - A repeat never fires in DEB_RELEASE.
- Undefined: no repeat logic is synthesized, key_repeat is tied to 0, and one press gives exactly one key_press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3):
- Clean press:
  - Stimulus: key_sw=4'b1110 from edge 0, held.
  - Required: key_press[0] high only in the cycle after edge 5; key_down[0] and any_down rise with it.
  - Required: other bits of key_press, key_down, key_release stay 0.
- Bounce rejection:
  - Stimulus: key_sw[1] low for 3 cycles, high 1 cycle, low 2 cycles, then high.
  - Required: no key_press or key_release on key 1; key_down[1] stays 0.
- Release:
  - Stimulus: after the clean press, key_sw[0] returns high at edge 20.
  - Required: key_release[0] single pulse after edge 25; key_down[0] falls at the same time; no extra key_press.
- Simultaneous keys:
  - Stimulus: key_sw 1111→0101 at the same edge.
  - Required: key_press=4'b1010 for exactly one cycle; key_down=4'b1010.
- Auto-repeat (macro defined):
  - Stimulus: hold key 2 for 30 cycles after acceptance.
  - Required: initial key_press[2] with key_repeat[2]=0; then key_press[2]=key_repeat[2]=1 at PRESSED-cycle offsets 10, 13, 16, …
  - Macro undefined: a single pulse only.
- Reset mid-hold:
  - Stimulus: key 3 accepted, then reset_n=0 for one edge while still held.
  - Required: all outputs 0 the next cycle with no key_release; a new key_press[3] DEBOUNCE_CYCLES+2 cycles after reset_n returns high.

Source files
------------

// File: rtl/key_event_gen_if.sv
// Key event bus: raw active-low buttons in, debounced levels and pulses out.
// Master drives the raw switch levels; slave (the generator) returns events.
interface key_event_gen_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_sw;
    logic [N_KEYS-1:0] key_down;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;
    logic              any_down;

    modport master (
        output key_sw,
        input  key_down, key_press, key_release, key_repeat, any_down
    );

    modport slave (
        input  key_sw,
        output key_down, key_press, key_release, key_repeat, any_down
    );
endinterface

// File: rtl/key_event_gen.sv
// Per-key debouncer/event generator; auto-repeat enabled by KEY_EVENT_GEN_AUTO_REPEAT_EN.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 cycles after key_sw settles (2-flop sync + debounce).
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module key_event_gen #(
    parameter int N_KEYS               = 4,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic           clk,
    input  logic           reset_n,
    key_event_gen_if.slave keys
);
    localparam int MAX_A  = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int MAX_C  = (MAX_A > REPEAT_PERIOD_CYCLES) ? MAX_A : REPEAT_PERIOD_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        RELEASED,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] down;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] rel;
    logic [N_KEYS-1:0] rpt;

    // Invert here so everything downstream sees 1 = pressed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~keys.key_sw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        state_t        state;
        logic [CW-1:0] cnt;
        logic          down_q;
        logic          press_q;
        logic          rel_q;
        logic          s;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
        logic [CW-1:0] rcnt;
        logic          rfirst;
        logic          rpt_q;
`endif

        assign s = sync2[i];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state   <= RELEASED;
                cnt     <= '0;
                down_q  <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
                rcnt    <= '0;
                rfirst  <= 1'b0;
                rpt_q   <= 1'b0;
`endif
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
                rpt_q   <= 1'b0;
`endif
                unique case (state)
                    RELEASED: begin
                        if (s) begin
                            state <= DEB_PRESS;
                            cnt   <= ONE;
                        end
                    end
                    DEB_PRESS: begin
                        if (!s) begin
                            state <= RELEASED;
                        end else if (cnt == DEB_LAST) begin
                            state   <= PRESSED;
                            press_q <= 1'b1;
                            down_q  <= 1'b1;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
                            rcnt    <= '0;
                            rfirst  <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    PRESSED: begin
                        if (!s) begin
                            state <= DEB_RELEASE;
                            cnt   <= ONE;
                        end
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
                        // Repeat timer only advances while held in PRESSED; frozen in DEB_RELEASE.
                        else if (rcnt == (rfirst ? RP_LAST : RD_LAST)) begin
                            press_q <= 1'b1;
                            rpt_q   <= 1'b1;
                            rcnt    <= '0;
                            rfirst  <= 1'b1;
                        end else begin
                            rcnt <= rcnt + ONE;
                        end
`endif
                    end
                    DEB_RELEASE: begin
                        if (s) begin
                            state <= PRESSED;
                        end else if (cnt == DEB_LAST) begin
                            state  <= RELEASED;
                            rel_q  <= 1'b1;
                            down_q <= 1'b0;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
                            rcnt   <= '0;
                            rfirst <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: state <= RELEASED;
                endcase
            end
        end

        assign down[i]  = down_q;
        assign press[i] = press_q;
        assign rel[i]   = rel_q;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
        assign rpt[i]   = rpt_q;
`else
        assign rpt[i]   = 1'b0;
`endif
    end

    assign keys.key_down    = down;
    assign keys.key_press   = press;
    assign keys.key_release = rel;
    assign keys.key_repeat  = rpt;
    assign keys.any_down    = |down;
endmodule

// File: tb/tb_key_event_gen.sv
// Directed vector bench for key_event_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_event_gen;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    key_event_gen_if #(.N_KEYS(N)) bus ();

    key_event_gen #(
        .N_KEYS              (N),
        .DEBOUNCE_CYCLES     (D),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_PERIOD_CYCLES(RP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .keys   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] sw;
        logic [3:0] down;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int idx, input logic [3:0] down,
                         input logic [3:0] press, input logic [3:0] rel, input logic [3:0] rpt);
        logic [16:0] got;
        logic [16:0] exp;
        got = {bus.key_down, bus.key_press, bus.key_release, bus.key_repeat, bus.any_down};
        exp = {down, press, rel, rpt, |down};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got down=%b press=%b rel=%b rpt=%b any=%b, want down=%b press=%b rel=%b rpt=%b any=%b",
                     nm, idx, bus.key_down, bus.key_press, bus.key_release, bus.key_repeat, bus.any_down,
                     down, press, rel, rpt, |down);
        end
    endtask

    // Key pattern sw held for `hold` vectors from released, then all released for 8 vectors.
    // Accept after edge 5, release after edge hold+5; repeats at 5+RD+m*RP while still held.
    task automatic add_block(input string nm, input logic [3:0] sw, input int hold);
        vec_t       v;
        logic [3:0] pk;
        pk = ~sw;
        for (int k = 0; k < hold + 8; k++) begin
            v.name  = nm;
            v.sw    = (k < hold) ? sw : 4'hF;
            v.down  = (k >= 5 && k < hold + 5) ? pk : 4'h0;
            v.press = (k == 5) ? pk : 4'h0;
            v.rel   = (k == hold + 5) ? pk : 4'h0;
            v.rpt   = 4'h0;
`ifdef KEY_EVENT_GEN_AUTO_REPEAT_EN
            if (k >= 5 + RD && k < hold + 2 && ((k - 5 - RD) % RP) == 0) begin
                v.press = pk;
                v.rpt   = pk;
            end
`endif
            vecs.push_back(v);
        end
    endtask

    task automatic add_vec(input string nm, input logic [3:0] sw);
        vec_t v;
        v.name = nm; v.sw = sw;
        v.down = 4'h0; v.press = 4'h0; v.rel = 4'h0; v.rpt = 4'h0;
        vecs.push_back(v);
    endtask

    initial begin
        add_block("clean_press", 4'b1110, 20);
        for (int k = 0; k < 3; k++) add_vec("bounce", 4'b1101);
        add_vec("bounce", 4'b1111);
        for (int k = 0; k < 2; k++) add_vec("bounce", 4'b1101);
        for (int k = 0; k < 8; k++) add_vec("bounce", 4'b1111);
        add_block("simultaneous", 4'b0101, 9);
        add_block("auto_repeat", 4'b1011, 34);

        bus.key_sw = 4'hF;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.key_sw = vecs[i].sw;
            @(posedge clk);
            #1;
            check(vecs[i].name, i, vecs[i].down, vecs[i].press, vecs[i].rel, vecs[i].rpt);
        end

        // Reset while key 3 is accepted and held: no release, then a fresh press.
        bus.key_sw = 4'b0111;
        repeat (8) @(posedge clk);
        #1;
        check("hold_before_reset", 0, 4'b1000, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_hold", 0, 4'h0, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            check("repress_after_reset", e, (e >= D + 2) ? 4'b1000 : 4'h0,
                  (e == D + 2) ? 4'b1000 : 4'h0, 4'h0, 4'h0);
        end
        bus.key_sw = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            check("release_after_reset", e, (e < D + 2) ? 4'b1000 : 4'h0, 4'h0,
                  (e == D + 2) ? 4'b1000 : 4'h0, 4'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
